// File: rtl/usb_tx.sv
// usb_tx: host-bound half of the FT245-style USB FIFO link.
// Bytes from internal logic are buffered in a small FIFO and written to the
// USB chip with timed WR strobes; a flush request queues one SI# pulse that
// is issued once every byte queued ahead of it has been written.
// Handshake: a byte transfers on a rising clk edge where tx_valid && tx_ready;
// tx_ready depends only on FIFO occupancy, never on tx_valid.
module usb_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int WR_HIGH_CYC = 5,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 8,
  parameter int SI_CYC      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  input  logic                         flush,
  input  logic                         txe,
  output logic                         wr,
  output logic                         si,
  output logic [7:0]                   d_out,
  output logic                         d_oe,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = 16;

  localparam logic [CW-1:0] WR_LAST  = CW'(WR_HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REC_LAST = CW'(RECOVER_CYC - 1);
  localparam logic [CW-1:0] SI_LAST  = CW'(SI_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_HI   = 3'd1,
    HOLD    = 3'd2,
    SI_LO   = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            si_pending;
  logic            txe_m;
  logic            txe_s;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  assign tx_ready = (level != LW'(FIFO_DEPTH));
  assign push     = tx_valid && tx_ready;
  // The head byte leaves the FIFO on the same edge the FSM starts a strobe.
  assign pop      = (state == IDLE) && (level != '0) && !txe_s;
  assign busy     = (level != '0) || si_pending || (state != IDLE);

  // Two-flop synchronizer for the asynchronous TXE#; resets to "chip full".
  always_ff @(posedge clk) begin
    if (rst) begin
      txe_m <= 1'b1;
      txe_s <= 1'b1;
    end else begin
      txe_m <= txe;
      txe_s <= txe_m;
    end
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Strobe sequencer: outputs are registered and take their per-state value
  // on the edge that enters the state. A flush arriving on the SI exit edge
  // is absorbed by the pulse already in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr         <= 1'b0;
      si         <= 1'b1;
      d_oe       <= 1'b0;
      d_out      <= 8'h00;
      si_pending <= 1'b0;
    end else begin
      if (flush) si_pending <= 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pop) begin
            d_out <= mem[rd_ptr];
            d_oe  <= 1'b1;
            wr    <= 1'b1;
            state <= WR_HI;
          end else if (si_pending && (level == '0) && !txe_s) begin
            si    <= 1'b0;
            state <= SI_LO;
          end
        end
        WR_HI: begin
          if (cnt == WR_LAST) begin
            wr    <= 1'b0;
            cnt   <= '0;
            state <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            d_oe  <= 1'b0;
            cnt   <= '0;
            state <= RECOVER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SI_LO: begin
          if (cnt == SI_LAST) begin
            si         <= 1'b1;
            si_pending <= 1'b0;
            cnt        <= '0;
            state      <= RECOVER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECOVER: begin
          if (cnt == REC_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: self-checking bench for usb_tx at default parameters.
module tb_usb_tx;

  localparam int LW = 5;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          flush;
  logic          txe;
  logic          wr;
  logic          si;
  logic [7:0]    d_out;
  logic          d_oe;
  logic          busy;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  usb_tx #(
    .FIFO_DEPTH(16), .WR_HIGH_CYC(5), .HOLD_CYC(1), .RECOVER_CYC(8), .SI_CYC(5)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .flush(flush), .txe(txe), .wr(wr), .si(si),
    .d_out(d_out), .d_oe(d_oe), .busy(busy), .level(level)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks  = 0;
  int         n_pass    = 0;
  int         si_pulses = 0;
  logic [7:0] exp_q[$];
  bit         rst_edge  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Remember whether the last active edge was a reset edge.
  always @(posedge clk) rst_edge = rst;

  // Monitor: every WR falling edge delivers the next expected byte; SI pulses
  // are counted and timed; WR and SI never active together.
  logic wr_p = 1'b0;
  logic si_p = 1'b1;
  int   si_len = 0;
  always @(negedge clk) begin
    check("wr_si_exclusive", {31'd0, wr & ~si}, 32'd0);
    if (!rst_edge) begin
      if (wr_p && !wr) begin
        check("hold_d_oe", {31'd0, d_oe}, 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: strobe wrote %0h with no byte expected", d_out);
        end else begin
          check("sb_d_out", {24'd0, d_out}, {24'd0, exp_q.pop_front()});
        end
      end
      if (si_p && !si) begin
        check("si_after_bytes", exp_q.size(), 32'd0);
        si_pulses++;
        si_len = 0;
      end
      if (!si) si_len++;
      if (!si_p && si) check("si_len", si_len, 32'd5);
    end
    wr_p = wr;
    si_p = si;
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    exp_q.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_wr_rise(output int n);
    logic prev;
    bit   seen;
    prev = wr;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (wr && !prev) seen = 1'b1;
      prev = wr;
    end
    check("wr_rise_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- single-byte timing table ----------------
  typedef struct {
    logic tv;
    logic e_wr;
    logic e_si;
    logic e_doe;
    logic e_busy;
  } vec_t;
  vec_t vec [17];

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    int  base;
    bit  activity;

    // Row i is sampled on the i-th falling edge; tv is driven for the next edge.
    vec[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 2; i <= 6; i++)  vec[i] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vec[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 8; i <= 15; i++) vec[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // ---- reset with tx_valid high ----
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h77; flush = 1'b0; txe = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_si", {31'd0, si}, 32'd1);
    check("rst_d_oe", {31'd0, d_oe}, 32'd0);
    check("rst_d_out", {24'd0, d_out}, 32'd0);
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; tx_valid = 1'b0;
    @(negedge clk);
    check("level_after_reset", {27'd0, level}, 32'd0);
    repeat (3) @(negedge clk);

    // ---- single byte 0xA5, cycle-by-cycle ----
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_wr", i), {31'd0, wr}, {31'd0, vec[i].e_wr});
      check($sformatf("vec%0d_si", i), {31'd0, si}, {31'd0, vec[i].e_si});
      check($sformatf("vec%0d_d_oe", i), {31'd0, d_oe}, {31'd0, vec[i].e_doe});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vec[i].e_busy});
      if (vec[i].e_doe) check($sformatf("vec%0d_d_out", i), {24'd0, d_out}, 32'hA5);
      tx_valid = vec[i].tv;
      tx_data  = 8'hA5;
      if (vec[i].tv) exp_q.push_back(8'hA5);
    end
    tx_valid = 1'b0;

    // ---- fill FIFO with txe high, then drain ----
    @(negedge clk);
    txe = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'(i);
      exp_q.push_back(8'(i));
    end
    @(negedge clk);
    check("full_level", {27'd0, level}, 32'd16);
    check("full_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("full_busy", {31'd0, busy}, 32'd1);
    tx_data = 8'hEE;
    @(negedge clk);
    tx_valid = 1'b0;
    check("full_no_push", {27'd0, level}, 32'd16);
    check("d_out_held", {24'd0, d_out}, 32'hA5);
    txe = 1'b0;
    wait_wr_rise(n);
    check("txe_latency", n, 32'd3);
    check("after_pop_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("after_pop_level", {27'd0, level}, 32'd15);
    wait_wr_rise(n);
    check("byte_period", n, 32'd15);
    wait_idle(16 * 15 + 40);
    check("drain_q_empty", exp_q.size(), 32'd0);

    // ---- two bytes then flush; second flush during SI is absorbed ----
    base = si_pulses;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h11; exp_q.push_back(8'h11);
    @(negedge clk);
    tx_data = 8'h22; exp_q.push_back(8'h22);
    @(negedge clk);
    tx_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n = 0;
    while (si && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("si_low_seen", {31'd0, si}, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle(100);
    check("flush_one_si", si_pulses - base, 32'd1);

    // ---- txe high holds back both bytes and SI ----
    base = si_pulses;
    @(negedge clk);
    txe = 1'b1;
    repeat (3) @(negedge clk);
    push_byte(8'h33);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    activity = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (wr || !si || d_oe) activity = 1'b1;
    end
    check("txe_high_quiet", {31'd0, activity}, 32'd0);
    check("txe_high_level", {27'd0, level}, 32'd1);
    check("txe_high_busy", {31'd0, busy}, 32'd1);
    txe = 1'b0;
    wait_wr_rise(n);
    check("txe_drop_latency", n, 32'd3);
    wait_idle(100);
    check("held_flush_one_si", si_pulses - base, 32'd1);

    // ---- reset in the middle of a WR strobe ----
    push_byte(8'h44);
    wait_wr_rise(n);
    tx_valid = 1'b1; tx_data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clk);
    tx_valid = 1'b0;
    check("mid_wr_level", {27'd0, level}, 32'd1);
    check("mid_wr_wr", {31'd0, wr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("midrst_wr", {31'd0, wr}, 32'd0);
    check("midrst_d_oe", {31'd0, d_oe}, 32'd0);
    check("midrst_level", {27'd0, level}, 32'd0);
    check("midrst_si", {31'd0, si}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    activity = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (wr || !si || d_oe || busy) activity = 1'b1;
    end
    check("post_rst_idle", {31'd0, activity}, 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
